tribus_arbiter: RTL

TRIBUS_ARBITER -- requirements
Module: tribus_arbiter

---
 rtl/tribus_pkg.sv | 15 +
 rtl/tribus_arbiter_if.sv | 17 +
 rtl/tribus_driver.sv | 10 +
 rtl/tribus_arbiter.sv | 77 +++++++
 4 files changed

// File: rtl/tribus_pkg.sv
// Shared types for the two-requester tristate bus arbiter.
package tribus_pkg;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, TURN} state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // Round-robin pick: on a tie the requester not served last wins.
  function automatic logic rr_pick(input logic req_a, input logic req_b, input logic last);
    if (req_a && req_b) return (last == OWNER_A) ? OWNER_B : OWNER_A;
    return req_a ? OWNER_A : OWNER_B;
  endfunction

endpackage

// File: rtl/tribus_arbiter_if.sv
// Requester handshake and capture signals of the tristate bus arbiter.
interface tribus_arbiter_if #(parameter int WIDTH = 8);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             busy;

  modport master (output req_a, req_b, data_a, data_b,
                  input  gnt_a, gnt_b, rd_valid, rd_data, busy);
  modport slave  (input  req_a, req_b, data_a, data_b,
                  output gnt_a, gnt_b, rd_valid, rd_data, busy);
endinterface

// File: rtl/tribus_driver.sv
// One tristate bus driver: data when enabled, otherwise all bits Z.
module tribus_driver #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output wire  [WIDTH-1:0] bus
);
  assign bus = en ? data : {WIDTH{1'bz}};
endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin owner of a shared tristate bus with hold limit and Z turnaround.
module tribus_arbiter
  import tribus_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  tribus_arbiter_if.slave  bif,
  inout  wire  [WIDTH-1:0] bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

  state_t           state_q, state_d;
  logic [7:0]       hold_q;
  logic [3:0]       turn_q;
  logic             last_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;

  logic own_a, own_b, beat, any_req, enter_own;
  state_t win_state;

  assign own_a     = (state_q == OWN_A);
  assign own_b     = (state_q == OWN_B);
  assign beat      = (own_a && bif.req_a) || (own_b && bif.req_b);
  assign any_req   = bif.req_a || bif.req_b;
  assign win_state = (rr_pick(bif.req_a, bif.req_b, last_q) == OWNER_A) ? OWN_A : OWN_B;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (any_req) state_d = win_state;
      OWN_A: if (!bif.req_a || hold_q == HOLD_LAST) state_d = TURN;
      OWN_B: if (!bif.req_b || hold_q == HOLD_LAST) state_d = TURN;
      TURN:  if (turn_q == TURN_LAST) state_d = any_req ? win_state : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_own = (state_q inside {IDLE, TURN}) && (state_d inside {OWN_A, OWN_B});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      turn_q     <= '0;
      last_q     <= OWNER_B;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= beat;
      if (beat) rd_data_q <= bus;
      if (enter_own) hold_q <= '0;
      else if (beat) hold_q <= hold_q + 8'd1;
      // turn_q is zero on the first TURN cycle and counts up while there
      turn_q <= (state_q == TURN) ? turn_q + 4'd1 : 4'd0;
      if (enter_own) last_q <= (state_d == OWN_B) ? OWNER_B : OWNER_A;
    end
  end

  // Enables decode straight from the state register, so reset releases the bus at once
  tribus_driver #(.WIDTH(WIDTH)) u_drv_a (.en(own_a), .data(bif.data_a), .bus(bus));
  tribus_driver #(.WIDTH(WIDTH)) u_drv_b (.en(own_b), .data(bif.data_b), .bus(bus));

  assign bif.gnt_a    = own_a;
  assign bif.gnt_b    = own_b;
  assign bif.busy     = (state_q != IDLE);
  assign bif.rd_valid = rd_valid_q;
  assign bif.rd_data  = rd_data_q;

endmodule
